// File: rtl/nios2_ls_de2_pio_ledr18_out.sv
// rtl/nios2_ls_de2_pio_ledr18_out.sv - 18-bit LED output PIO with set/clear strobes and blink engine
module nios2_ls_de2_pio_ledr18_out #(
    parameter int BLINK_W = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [17:0] out_port
);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_MASK   = 3'd1;
    localparam logic [2:0] ADDR_PERIOD = 3'd2;
    localparam logic [2:0] ADDR_CTRL   = 3'd3;
    localparam logic [2:0] ADDR_SET    = 3'd4;
    localparam logic [2:0] ADDR_CLEAR  = 3'd5;

    logic [17:0]        data;
    logic [17:0]        mask;
    logic [BLINK_W-1:0] period;
    logic [BLINK_W-1:0] period_next;
    logic [BLINK_W-1:0] counter;
    logic               en;
    logic               phase;
    logic               wr;
    logic               ctrl_wr;
    logic [31:0]        read_mux;
    logic               unused_bits;

    assign wr          = chipselect & ~write_n;
    assign ctrl_wr     = wr && (address == ADDR_CTRL);
    assign unused_bits = ^writedata;

    // A period write landing on a reload edge must be seen by that reload
    always_comb begin
        period_next = period;
        if (wr && (address == ADDR_PERIOD))
            period_next = writedata[BLINK_W-1:0];
    end

    // Software-visible data, mask and period registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data   <= '0;
            mask   <= '0;
            period <= '0;
        end else begin
            period <= period_next;
            if (wr) begin
                case (address)
                    ADDR_DATA:  data <= writedata[17:0];
                    ADDR_MASK:  mask <= writedata[17:0];
                    ADDR_SET:   data <= data | writedata[17:0];
                    ADDR_CLEAR: data <= data & ~writedata[17:0];
                    default:    ;
                endcase
            end
        end
    end

    // Blink engine: EN, PHASE and the down-counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en      <= 1'b0;
            phase   <= 1'b0;
            counter <= '0;
        end else if (ctrl_wr && !writedata[0]) begin
            en      <= 1'b0;
            phase   <= 1'b0;
            counter <= period_next;
        end else if (ctrl_wr && !en) begin
            // Rising enable: fresh full-length first phase, countdown starts next cycle
            en      <= 1'b1;
            phase   <= 1'b0;
            counter <= period_next;
        end else if (en) begin
            if (counter == '0) begin
                counter <= period_next;
                phase   <= ~phase;
            end else begin
                counter <= counter - 1'b1;
            end
        end else begin
            phase   <= 1'b0;
            counter <= period_next;
        end
    end

    // Read mux; reserved and write-only words read as zero
    always_comb begin
        read_mux = '0;
        case (address)
            ADDR_DATA:   read_mux = {14'd0, data};
            ADDR_MASK:   read_mux = {14'd0, mask};
            ADDR_PERIOD: read_mux = 32'(period);
            ADDR_CTRL:   read_mux = {30'd0, phase, en};
            default:     read_mux = '0;
        endcase
    end

    // Read data is registered every cycle, independent of chipselect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            readdata <= '0;
        else
            readdata <= read_mux;
    end

    assign out_port = data & ~(mask & {18{en & phase}});

endmodule

// File: tb/tb_nios2_ls_de2_pio_ledr18_out.sv
// tb/tb_nios2_ls_de2_pio_ledr18_out.sv - self-checking bench for the LED output PIO
module tb_nios2_ls_de2_pio_ledr18_out;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [17:0] out_port;

    int checks;
    int errors;

    nios2_ls_de2_pio_ledr18_out #(.BLINK_W(24)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [17:0] exp_out;
        logic [2:0]  rd_addr;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        address = a;
        step();
        d = readdata;
    endtask

    function automatic logic [17:0] blink_out(input logic ph);
        return ph ? 18'h3FFFC : 18'h3FFFF;
    endfunction

    function automatic logic mid_phase(input int i);
        if (i < 10) return 1'b0;
        return (((i - 10) / 3) % 2) == 0;
    endfunction

    logic [31:0] r;
    logic        ph;

    initial begin
        checks     = 0;
        errors     = 0;
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;

        vecs[0] = '{3'd0, 32'hFFFF_FFFF, 18'h3FFFF, 3'd0, 32'h0003_FFFF};
        vecs[1] = '{3'd5, 32'h0000_0F0F, 18'h3F0F0, 3'd0, 32'h0003_F0F0};
        vecs[2] = '{3'd4, 32'h0000_0005, 18'h3F0F5, 3'd0, 32'h0003_F0F5};
        vecs[3] = '{3'd6, 32'h0003_FFFF, 18'h3F0F5, 3'd4, 32'h0000_0000};
        vecs[4] = '{3'd7, 32'h0000_0000, 18'h3F0F5, 3'd5, 32'h0000_0000};
        vecs[5] = '{3'd1, 32'h000F_FFFF, 18'h3F0F5, 3'd1, 32'h0003_FFFF};
        vecs[6] = '{3'd2, 32'h0123_4567, 18'h3F0F5, 3'd2, 32'h0023_4567};
        vecs[7] = '{3'd3, 32'h0000_0002, 18'h3F0F5, 3'd3, 32'h0000_0000};
        vecs[8] = '{3'd1, 32'h0000_0000, 18'h3F0F5, 3'd1, 32'h0000_0000};
        vecs[9] = '{3'd0, 32'h0003_FFFF, 18'h3FFFF, 3'd6, 32'h0000_0000};

        repeat (2) @(posedge clk);
        #1;
        check("reset_out", 32'(out_port), 32'h0);
        check("reset_rd", readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 10; i++) begin
            wr(vecs[i].addr, vecs[i].wdata);
            check($sformatf("vec%0d_out", i), 32'(out_port), 32'(vecs[i].exp_out));
            rd(vecs[i].rd_addr, r);
            check($sformatf("vec%0d_rd", i), r, vecs[i].exp_rd);
        end

        // Blink: PERIOD=4 gives 5-cycle phases on bits [1:0]
        wr(3'd1, 32'h3);
        wr(3'd2, 32'd4);
        wr(3'd3, 32'h1);
        check("blink_i0", 32'(out_port), 32'(blink_out(1'b0)));
        for (int i = 1; i < 15; i++) begin
            step();
            check($sformatf("blink_i%0d", i), 32'(out_port), 32'(blink_out(((i / 5) % 2) == 1)));
            ph = (((i - 1) / 5) % 2) == 1;
            check($sformatf("blink_ctrl%0d", i), readdata, {30'd0, ph, 1'b1});
        end

        // Period 0: toggle every cycle
        wr(3'd3, 32'h0);
        wr(3'd2, 32'd0);
        wr(3'd3, 32'h1);
        check("p0_i0", 32'(out_port), 32'(blink_out(1'b0)));
        for (int i = 1; i < 6; i++) begin
            step();
            check($sformatf("p0_i%0d", i), 32'(out_port), 32'(blink_out((i % 2) == 1)));
        end
        // DATA clear coinciding with a toggle edge
        wr(3'd5, 32'h0001_0000);
        check("sim_clr_toggle", 32'(out_port), 32'h2FFFF);
        step();
        check("sim_clr_next", 32'(out_port), 32'h2FFFC);
        wr(3'd4, 32'h0001_0000);
        check("sim_set_toggle", 32'(out_port), 32'h3FFFF);

        // Mid-run period change: 10-cycle phase, then 3-cycle phases
        wr(3'd3, 32'h0);
        wr(3'd2, 32'd9);
        wr(3'd3, 32'h1);
        check("mid_i0", 32'(out_port), 32'(blink_out(mid_phase(0))));
        for (int i = 1; i < 4; i++) begin
            step();
            check($sformatf("mid_i%0d", i), 32'(out_port), 32'(blink_out(mid_phase(i))));
        end
        wr(3'd2, 32'd2);
        check("mid_i4", 32'(out_port), 32'(blink_out(mid_phase(4))));
        for (int i = 5; i < 22; i++) begin
            step();
            check($sformatf("mid_i%0d", i), 32'(out_port), 32'(blink_out(mid_phase(i))));
        end

        // Disable while PHASE=1, then re-enable
        wr(3'd3, 32'h0);
        wr(3'd2, 32'd4);
        wr(3'd3, 32'h1);
        repeat (6) step();
        check("dis_pre", 32'(out_port), 32'h3FFFC);
        wr(3'd3, 32'h0);
        check("dis_out", 32'(out_port), 32'h3FFFF);
        rd(3'd3, r);
        check("dis_ctrl", r, 32'h0);
        wr(3'd3, 32'h1);
        for (int i = 1; i < 7; i++) begin
            step();
            check($sformatf("reen_i%0d", i), 32'(out_port), 32'(blink_out(i >= 5)));
        end

        // Asynchronous reset mid-blink (currently PHASE=1)
        address = 3'd0;
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_out", 32'(out_port), 32'h0);
        check("arst_rd", readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        for (int a = 0; a < 4; a++) begin
            rd(3'(a), r);
            check($sformatf("post_rst_rd%0d", a), r, 32'h0);
        end
        step();
        check("post_rst_out", 32'(out_port), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
